// File: rtl/conv_ff_pkg.sv
// Shared types and the mode-to-toggle conversion for conv_ff_bank.
package conv_ff_pkg;

    typedef enum logic [1:0] {
        MODE_D  = 2'd0,
        MODE_T  = 2'd1,
        MODE_JK = 2'd2,
        MODE_SR = 2'd3
    } ff_mode_t;

    // Converts one bit of D/T/JK/SR input into the toggle enable for a T flip-flop.
    function automatic logic to_toggle(ff_mode_t mode, logic a, logic b, logic q);
        logic t;
        t = 1'b0;
        unique case (mode)
            MODE_D:  t = a ^ q;
            MODE_T:  t = a;
            MODE_JK: t = (a & ~q) | (b & q);
            MODE_SR: t = (a & b) ? 1'b0 : ((a & ~q) | (b & q));
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with clock enable and asynchronous active-low reset.
module tff_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic t,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else if (en && t) begin
            q_q <= ~q_q;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/conv_ff_bank.sv
// Run-time selectable D/T/JK/SR flip-flop bank built on T flip-flops.
// Define CONV_FF_TOGCNT_EN to build in the saturating toggle-activity counter.
module conv_ff_bank
    import conv_ff_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned CW      = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          err_clr,
    input  logic          cnt_clr,
    output logic [W-1:0]  q,
    output logic          err,
    output logic [CW-1:0] tog_cnt
);

    ff_mode_t     mode_e;
    logic [W-1:0] t;
    logic         err_set;
    logic         err_q;

    assign mode_e = ff_mode_t'(mode);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign t[i] = to_toggle(mode_e, a[i], b[i], q[i]);

        tff_cell #(
            .RST_VAL(RST_VAL[i])
        ) u_tff (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .t    (t[i]),
            .q    (q[i])
        );
    end

    // A new illegal SR input outranks a simultaneous clear.
    assign err_set = en && (mode_e == MODE_SR) && (|(a & b));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;

`ifdef CONV_FF_TOGCNT_EN
    localparam int unsigned PW = $clog2(W + 1);
    localparam int unsigned SW = ((CW > PW) ? CW : PW) + 1;
    localparam logic [CW-1:0] CntMax = '1;

    logic [PW-1:0] pop;
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + PW'(t[i]);
        end
        sum   = SW'(cnt_q) + SW'(pop);
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (sum > SW'(CntMax)) ? CntMax : sum[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tog_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign tog_cnt        = '0;
`endif

endmodule

// File: tb/tb_conv_ff_bank.sv
// Self-checking bench for conv_ff_bank: directed literal cases plus randomized traffic vs. a model.
module tb_conv_ff_bank;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;
    localparam logic [7:0] RV  = 8'hA5;
    localparam int CMAX        = 15;
`ifdef CONV_FF_TOGCNT_EN
    localparam bit TOG_EN = 1'b1;
`else
    localparam bit TOG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          err_clr = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [W-1:0]  q;
    logic          err;
    logic [CW-1:0] tog_cnt;

    conv_ff_bank #(
        .W      (W),
        .CW     (CW),
        .RST_VAL(RV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .err_clr(err_clr),
        .cnt_clr(cnt_clr),
        .q      (q),
        .err    (err),
        .tog_cnt(tog_cnt)
    );

    always #5 clk = ~clk;

    // Characteristic equations of each flip-flop type, applied to the whole byte.
    function automatic logic [7:0] next_q(logic [1:0] m, logic [7:0] cq, logic [7:0] ia,
                                          logic [7:0] ib, logic ien);
        logic [7:0] r;
        r = cq;
        if (ien) begin
            case (m)
                2'd0: r = ia;
                2'd1: r = cq ^ ia;
                2'd2: r = (ia & ~cq) | (~ib & cq);
                default: begin
                    for (int i = 0; i < 8; i++) begin
                        if (ia[i] && !ib[i]) r[i] = 1'b1;
                        else if (ib[i] && !ia[i]) r[i] = 1'b0;
                    end
                end
            endcase
        end
        return r;
    endfunction

    function automatic int next_cnt(int c, int toggles, logic iclr, logic ien);
        int s;
        if (!TOG_EN || iclr) return 0;
        if (!ien) return c;
        s = c + toggles;
        return (s > CMAX) ? CMAX : s;
    endfunction

    logic [7:0] mdl_q;
    logic       mdl_err;
    int         mdl_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_q   <= RV;
            mdl_err <= 1'b0;
            mdl_cnt <= 0;
        end else begin
            mdl_q   <= next_q(mode, mdl_q, a, b, en);
            mdl_err <= (en && mode == 2'd3 && (|(a & b))) ? 1'b1 :
                       (err_clr ? 1'b0 : mdl_err);
            mdl_cnt <= next_cnt(mdl_cnt, $countones(next_q(mode, mdl_q, a, b, en) ^ mdl_q),
                                cnt_clr, en);
        end
    end

    int          checks = 0;
    int          failures = 0;
    bit          chk_en = 1'b0;
    int          lit_id = 0;
    int          seen_id = 0;
    logic [7:0]  lit_q;
    logic        lit_err;
    int          lit_cnt;
    string       lit_name;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: model every negedge, plus any pending literal expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("q_vs_model", 32'(q), 32'(mdl_q));
            chk("err_vs_model", 32'(err), 32'(mdl_err));
            chk("cnt_vs_model", 32'(tog_cnt), 32'(mdl_cnt));
            if (lit_id != seen_id) begin
                seen_id = lit_id;
                chk({lit_name, "_q"}, 32'(q), 32'(lit_q));
                chk({lit_name, "_err"}, 32'(err), 32'(lit_err));
                chk({lit_name, "_cnt"}, 32'(tog_cnt), 32'(lit_cnt));
            end
        end
    end

    task automatic expect_lit(string name, logic [7:0] eq, logic ee, int ec);
        lit_name = name;
        lit_q    = eq;
        lit_err  = ee;
        lit_cnt  = TOG_EN ? ec : 0;
        lit_id++;
    endtask

    // Drive inputs (at posedge+2), let one edge happen, return at the next posedge+2.
    task automatic step(logic [1:0] m, logic [7:0] ia, logic [7:0] ib, logic ien,
                        logic iec, logic icc);
        mode    = m;
        a       = ia;
        b       = ib;
        en      = ien;
        err_clr = iec;
        cnt_clr = icc;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        expect_lit("por", RV, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        step(2'd0, 8'h00, 8'h00, 1, 0, 0); expect_lit("d_load0", 8'h00, 0, 4);
        step(2'd0, 8'h00, 8'h00, 1, 0, 1); expect_lit("cnt_clr", 8'h00, 0, 0);
        step(2'd0, 8'h3C, 8'h00, 1, 0, 0); expect_lit("d_3c", 8'h3C, 0, 4);
        step(2'd0, 8'hC3, 8'h00, 0, 0, 0); expect_lit("d_hold", 8'h3C, 0, 4);
        step(2'd0, 8'h0F, 8'h00, 1, 0, 1); expect_lit("d_0f", 8'h0F, 0, 0);
        step(2'd2, 8'hFF, 8'hFF, 1, 0, 0); expect_lit("jk_tog", 8'hF0, 0, 8);
        step(2'd2, 8'h00, 8'hF0, 1, 0, 0); expect_lit("jk_rst", 8'h00, 0, 12);
        step(2'd3, 8'h81, 8'h01, 1, 0, 1); expect_lit("sr_ill", 8'h80, 1, 0);
        step(2'd3, 8'h00, 8'h00, 1, 1, 0); expect_lit("sr_clr", 8'h80, 0, 0);
        step(2'd3, 8'h01, 8'h01, 1, 1, 0); expect_lit("sr_setwin", 8'h80, 1, 0);
        step(2'd3, 8'h01, 8'h01, 0, 1, 0); expect_lit("sr_clr_noen", 8'h80, 0, 0);
        step(2'd1, 8'hFF, 8'h00, 1, 0, 0); expect_lit("t_1", 8'h7F, 0, 8);
        step(2'd1, 8'hFF, 8'h00, 1, 0, 0); expect_lit("t_sat", 8'h80, 0, 15);
        step(2'd1, 8'hFF, 8'h00, 1, 0, 1); expect_lit("t_clr", 8'h7F, 0, 0);

        // Mid-cycle asynchronous reset, checked before any further rising edge.
        @(negedge clk);
        en      = 1'b0;
        cnt_clr = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        expect_lit("async_rst", RV, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #1 rst_n = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b1;
            end
            step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 6) == 0));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
